mem_bus_arbiter: RTL

//  Shares one SRAM-like memory bus between the fetch port (inst) and the MEM-stage data port.
//  The data port is fed by the load/store byte-lane formatter.

---
 rtl/mem_bus_arbiter_pkg.sv | 27 ++
 rtl/mem_bus_arbiter_if.sv | 54 +++++
 rtl/mem_bus_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the inst/data memory bus arbiter.
// Holds the FSM states, grant ids, bus size codes and the round-robin pick.
package mem_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   typedef enum logic {
      GRANT_INST = 1'b0,
      GRANT_DATA = 1'b1
   } grant_t;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   // Under contention the port that did not win last time goes next.
   function automatic grant_t pick_grant(input logic inst_req, input logic data_req,
                                         input grant_t last_grant);
      if (inst_req && data_req) return (last_grant == GRANT_INST) ? GRANT_DATA : GRANT_INST;
      return data_req ? GRANT_DATA : GRANT_INST;
   endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// CPU fetch/data ports plus the shared memory bus, as seen by the arbiter.
// master = arbiter side; slave = core ports and bus bridge side.
interface mem_bus_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  inst_req;
   logic [ADDR_W-1:0]     inst_addr;
   logic                  inst_addr_ok;
   logic                  inst_data_ok;
   logic [DATA_W-1:0]     inst_rdata;

   logic                  data_req;
   logic                  data_wr;
   logic [1:0]            data_size;
   logic [ADDR_W-1:0]     data_addr;
   logic [DATA_W-1:0]     data_wdata;
   logic [DATA_W/8-1:0]   data_be;
   logic                  data_addr_ok;
   logic                  data_data_ok;
   logic [DATA_W-1:0]     data_rdata;

   logic                  bus_req;
   logic                  bus_wr;
   logic [1:0]            bus_size;
   logic [ADDR_W-1:0]     bus_addr;
   logic [DATA_W-1:0]     bus_wdata;
   logic [DATA_W/8-1:0]   bus_be;
   logic                  bus_addr_ok;
   logic                  bus_data_ok;
   logic [DATA_W-1:0]     bus_rdata;

   logic                  busy;

   modport master (
      input  inst_req, inst_addr,
      output inst_addr_ok, inst_data_ok, inst_rdata,
      input  data_req, data_wr, data_size, data_addr, data_wdata, data_be,
      output data_addr_ok, data_data_ok, data_rdata,
      output bus_req, bus_wr, bus_size, bus_addr, bus_wdata, bus_be,
      input  bus_addr_ok, bus_data_ok, bus_rdata,
      output busy
   );

   modport slave (
      output inst_req, inst_addr,
      input  inst_addr_ok, inst_data_ok, inst_rdata,
      output data_req, data_wr, data_size, data_addr, data_wdata, data_be,
      input  data_addr_ok, data_data_ok, data_rdata,
      input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata, bus_be,
      output bus_addr_ok, bus_data_ok, bus_rdata,
      input  busy
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one SRAM-like bus between fetch and data ports, one access in flight.
// Latency: req in IDLE -> bus_req next cycle -> *_data_ok one cycle after bus_data_ok; losers hold req.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic         clk,
   input  logic         rst,
   mem_bus_arbiter_if.master port
);
   localparam int BE_W = DATA_W / 8;

   state_t              state_q, state_d;
   grant_t              last_grant_q, grant_d;
   logic                take;
   logic                rsp;
   logic                inst_addr_ok, data_addr_ok;

   logic                bus_wr_q;
   logic [1:0]          bus_size_q;
   logic [ADDR_W-1:0]   bus_addr_q;
   logic [DATA_W-1:0]   bus_wdata_q;
   logic [BE_W-1:0]     bus_be_q;
   logic                inst_data_ok_q, data_data_ok_q;
   logic [DATA_W-1:0]   inst_rdata_q, data_rdata_q;

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = last_grant_q;
      take         = 1'b0;
      rsp          = 1'b0;
      inst_addr_ok = 1'b0;
      data_addr_ok = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (port.inst_req || port.data_req) begin
               grant_d = pick_grant(port.inst_req, port.data_req, last_grant_q);
               take    = 1'b1;
               state_d = ST_ADDR;
            end
         end
         ST_ADDR: begin
            // bus_data_ok alongside addr_ok is deliberately not honoured here
            if (port.bus_addr_ok) begin
               inst_addr_ok = (last_grant_q == GRANT_INST);
               data_addr_ok = (last_grant_q == GRANT_DATA);
               state_d      = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (port.bus_data_ok) begin
               rsp     = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_q   <= GRANT_INST;
         bus_wr_q       <= 1'b0;
         bus_size_q     <= 2'd0;
         bus_addr_q     <= '0;
         bus_wdata_q    <= '0;
         bus_be_q       <= '0;
         inst_data_ok_q <= 1'b0;
         data_data_ok_q <= 1'b0;
         inst_rdata_q   <= '0;
         data_rdata_q   <= '0;
      end else begin
         last_grant_q   <= grant_d;
         inst_data_ok_q <= rsp && (last_grant_q == GRANT_INST);
         data_data_ok_q <= rsp && (last_grant_q == GRANT_DATA);
         if (take) begin
            if (grant_d == GRANT_DATA) begin
               bus_wr_q    <= port.data_wr;
               bus_size_q  <= port.data_size;
               bus_addr_q  <= port.data_addr;
               bus_wdata_q <= port.data_wdata;
               bus_be_q    <= port.data_be;
            end else begin
               bus_wr_q    <= 1'b0;
               bus_size_q  <= SIZE_WORD;
               bus_addr_q  <= port.inst_addr;
               bus_wdata_q <= '0;
               bus_be_q    <= '1;
            end
         end
         // Store responses carry no data, so the load register keeps its last value.
         if (rsp && (last_grant_q == GRANT_INST)) inst_rdata_q <= port.bus_rdata;
         if (rsp && (last_grant_q == GRANT_DATA) && !bus_wr_q) data_rdata_q <= port.bus_rdata;
      end
   end

   assign port.inst_addr_ok = inst_addr_ok;
   assign port.data_addr_ok = data_addr_ok;
   assign port.inst_data_ok = inst_data_ok_q;
   assign port.data_data_ok = data_data_ok_q;
   assign port.inst_rdata   = inst_rdata_q;
   assign port.data_rdata   = data_rdata_q;
   assign port.bus_req      = (state_q == ST_ADDR);
   assign port.bus_wr       = bus_wr_q;
   assign port.bus_size     = bus_size_q;
   assign port.bus_addr     = bus_addr_q;
   assign port.bus_wdata    = bus_wdata_q;
   assign port.bus_be       = bus_be_q;
   assign port.busy         = (state_q != ST_IDLE);

endmodule
